// File: rtl/median_window_gen.sv
// Raster-scan 3x3 window generator: two line buffers feed three column shift registers.
// Optional MEDIAN_WIN_COORD_EN adds win_x/win_y centre-coordinate outputs.
module median_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] C,
  output logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] E,
  output logic [DATA_W-1:0] F,
  output logic [DATA_W-1:0] G,
  output logic [DATA_W-1:0] H,
  output logic [DATA_W-1:0] I,
  output logic              win_valid
`ifdef MEDIAN_WIN_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col_reg, cur_col;
  logic [RW-1:0]     row_reg, cur_row;
  logic              win_hit;
  logic              win_valid_reg;
  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  // sof on an accepted pixel pins it to (0,0) regardless of the running count
  always_comb begin
    cur_col = col_reg;
    cur_row = row_reg;
    if (sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  assign win_hit = pix_valid && (cur_col >= CW'(2)) && (cur_row >= RW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (pix_valid) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_reg <= '0;
        row_reg <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_reg <= cur_col + CW'(1);
        row_reg <= cur_row;
      end
    end
  end

  // Asynchronous read so the old line values join the pixel on its accepting edge
  assign lb0_rd = lb0_mem[cur_col];
  assign lb1_rd = lb1_mem[cur_col];

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1_mem[cur_col] <= pix_in;
      lb0_mem[cur_col] <= lb1_rd;
    end
  end

  // Row gi of the window: tap_reg[0] is the left (oldest) column, tap_reg[2] the newest
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_W-1:0] tap_reg [3];
      logic [DATA_W-1:0] col_in;
      assign col_in = (gi == 0) ? lb0_rd : ((gi == 1) ? lb1_rd : pix_in);

      always_ff @(posedge clk) begin
        if (rst) begin
          tap_reg[0] <= '0;
          tap_reg[1] <= '0;
          tap_reg[2] <= '0;
        end else if (pix_valid) begin
          tap_reg[0] <= tap_reg[1];
          tap_reg[1] <= tap_reg[2];
          tap_reg[2] <= col_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) win_valid_reg <= 1'b0;
    else     win_valid_reg <= win_hit;
  end

  assign A = g_row[0].tap_reg[0];
  assign B = g_row[0].tap_reg[1];
  assign C = g_row[0].tap_reg[2];
  assign D = g_row[1].tap_reg[0];
  assign E = g_row[1].tap_reg[1];
  assign F = g_row[1].tap_reg[2];
  assign G = g_row[2].tap_reg[0];
  assign H = g_row[2].tap_reg[1];
  assign I = g_row[2].tap_reg[2];
  assign win_valid = win_valid_reg;

`ifdef MEDIAN_WIN_COORD_EN
  logic [CW-1:0] win_x_reg;
  logic [RW-1:0] win_y_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_x_reg <= '0;
      win_y_reg <= '0;
    end else if (win_hit) begin
      win_x_reg <= cur_col - CW'(1);
      win_y_reg <= cur_row - RW'(1);
    end
  end

  assign win_x = win_x_reg;
  assign win_y = win_y_reg;
`else
  // Coordinate outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen on a 4x4 frame (plus a 5x3 coordinate check
// when MEDIAN_WIN_COORD_EN is defined).
module tb_median_window_gen;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int HT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic          sof;
  logic [DW-1:0] pix_in;
  logic [DW-1:0] A, B, C, D, E, F, G, H, I;
  logic          win_valid;
`ifdef MEDIAN_WIN_COORD_EN
  logic [1:0]    win_x, win_y;
  logic          rst2, pix_valid2, sof2;
  logic [DW-1:0] pix_in2;
  logic [DW-1:0] A2, B2, C2, D2, E2, F2, G2, H2, I2;
  logic          win_valid2;
  logic [2:0]    win_x2;
  logic [1:0]    win_y2;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int n_win;
  logic [DW-1:0] e_log [$];
  logic [DW-1:0] e_exp [4];

  always #5 clk = ~clk;

  median_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(HT)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H), .I(I),
    .win_valid(win_valid)
`ifdef MEDIAN_WIN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

`ifdef MEDIAN_WIN_COORD_EN
  median_window_gen #(.DATA_W(DW), .IMG_W(5), .IMG_H(3)) dut2 (
    .clk(clk), .rst(rst2), .pix_in(pix_in2), .pix_valid(pix_valid2), .sof(sof2),
    .A(A2), .B(B2), .C(C2), .D(D2), .E(E2), .F(F2), .G(G2), .H(H2), .I(I2),
    .win_valid(win_valid2), .win_x(win_x2), .win_y(win_y2)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted pixel at (x,y) of a frame whose pixels are base + y*16 + x
  task automatic push(input int x, input int y, input int base, input bit s);
    logic [DW-1:0] obs [9];
    logic [DW-1:0] exp;
    bit            exp_v;
    @(negedge clk);
    pix_valid = 1'b1;
    sof       = s;
    pix_in    = DW'(base + y * 16 + x);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    exp_v = (x >= 2) && (y >= 2);
    chk($sformatf("win_valid(%0d,%0d)", x, y), {31'd0, win_valid}, {31'd0, exp_v});
    if (exp_v) begin
      obs = '{A, B, C, D, E, F, G, H, I};
      for (int k = 0; k < 9; k++) begin
        exp = DW'(base + (y - 2 + k / 3) * 16 + (x - 2 + k % 3));
        chk($sformatf("win[%0d]@(%0d,%0d)", k, x, y), {24'd0, obs[k]}, {24'd0, exp});
      end
`ifdef MEDIAN_WIN_COORD_EN
      chk("win_x", {30'd0, win_x}, 32'(x - 1));
      chk("win_y", {30'd0, win_y}, 32'(y - 1));
`endif
      n_win++;
      e_log.push_back(E);
      $display("win  pix(%0d,%0d)  A=%h B=%h C=%h D=%h E=%h F=%h G=%h H=%h I=%h",
               x, y, A, B, C, D, E, F, G, H, I);
    end
  endtask

  // Idle cycles: sof toggles but must be ignored; outputs hold
  task automatic idle(input int n);
    logic [DW-1:0] held;
    held = E;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pix_valid = 1'b0;
      sof       = $urandom_range(0, 1) == 1;
      pix_in    = DW'($urandom);
      @(posedge clk);
      #1;
      chk("idle_win_valid", {31'd0, win_valid}, 32'd0);
      chk("idle_hold_E", {24'd0, E}, {24'd0, held});
    end
    sof = 1'b0;
  endtask

  task automatic frame(input int base, input bit use_sof, input bit gaps);
    n_win = 0;
    e_log.delete();
    for (int y = 0; y < HT; y++) begin
      for (int x = 0; x < W; x++) begin
        push(x, y, base, use_sof && x == 0 && y == 0);
        if (gaps) idle(((x + y) % 2 == 0) ? 1 : $urandom_range(0, 3));
      end
    end
    chk("frame_win_count", n_win, 4);
    for (int k = 0; k < 4 && k < e_log.size(); k++)
      chk($sformatf("frame_E%0d", k), {24'd0, e_log[k]}, 32'(base) + {24'd0, e_exp[k]});
  endtask

  initial begin
    e_exp = '{8'h11, 8'h12, 8'h21, 8'h22};
    rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
`ifdef MEDIAN_WIN_COORD_EN
    rst2 = 1'b1; pix_valid2 = 1'b0; sof2 = 1'b0; pix_in2 = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_win_valid", {31'd0, win_valid}, 32'd0);
    chk("rst_A", {24'd0, A}, 32'd0);
    chk("rst_E", {24'd0, E}, 32'd0);
    chk("rst_I", {24'd0, I}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef MEDIAN_WIN_COORD_EN
    rst2 = 1'b0;
`endif

    // Clean frame, continuous
    frame(0, 1'b1, 1'b0);
    // Same frame with gaps between pixels
    frame(0, 1'b1, 1'b1);
    // Back-to-back frames, second without sof
    frame(0, 1'b1, 1'b0);
    frame('h40, 1'b0, 1'b0);
    chk("b2b_first_E", {24'd0, e_log.size() > 0 ? e_log[0] : 8'h00}, 32'h51);

    // Partial frame, then reset during row 2
    n_win = 0;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < W; x++)
        push(x, y, 'h80, x == 0 && y == 0);
    push(0, 2, 'h80, 1'b0);
    push(1, 2, 'h80, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_win_valid", {31'd0, win_valid}, 32'd0);
    chk("midrst_E", {24'd0, E}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    frame(0, 1'b1, 1'b0);
    chk("post_rst_first_E", {24'd0, e_log.size() > 0 ? e_log[0] : 8'hff}, 32'h11);

`ifdef MEDIAN_WIN_COORD_EN
    n_win = 0;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 5; x++) begin
        @(negedge clk);
        pix_valid2 = 1'b1;
        sof2       = (x == 0 && y == 0);
        pix_in2    = DW'(y * 16 + x);
        @(posedge clk);
        #1;
        pix_valid2 = 1'b0;
        sof2       = 1'b0;
        chk($sformatf("c_valid(%0d,%0d)", x, y), {31'd0, win_valid2}, {31'd0, (x >= 2 && y >= 2)});
        if (x >= 2 && y >= 2) begin
          chk("c_win_x", {29'd0, win_x2}, 32'(x - 1));
          chk("c_win_y", {30'd0, win_y2}, 32'd1);
          chk("c_E", {24'd0, E2}, 32'h10 + 32'(x - 1));
          n_win++;
          $display("coord win x=%0d y=%0d E=%h", win_x2, win_y2, E2);
        end
      end
    end
    chk("coord_win_count", n_win, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
